seg_scan_8421_2b: RTL and testbench

- Display-side consumer of the two-digit 8421 BCD counter bus: captures the 8-bit BCD count `Q` and carry `TC` from the counter.
- Time-multiplexes the two digits onto a shared 7-segment bus with one-hot digit enables.
- Adds leading-zero blanking, invalid-BCD flagging and a stretched carry indicator on the decimal point.
- Sits between the counter and the board display pins.

---
 rtl/seg_scan_8421_2b.sv | 184 ++++++++++++++++++
 tb/tb_seg_scan_8421_2b.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_8421_2b.sv
// seg_scan_8421_2b
// Display-side consumer of a two-digit 8421 BCD counter. It captures the BCD
// count and the carry pulse, then time-multiplexes both digits onto a shared
// 7-segment bus with one-hot digit enables. It also provides leading-zero
// blanking, a non-BCD error flag and a stretched carry indication on the
// decimal point.
//
// Ports:
//   CP   in   1  clock, rising edge
//   CR   in   1  asynchronous clear, active-low
//   EN   in   1  scan enable; 0 = display dark, scan position held
//   LD   in   1  capture strobe for D
//   D    in   8  BCD value, D[7:4] = tens, D[3:0] = ones
//   TC   in   1  carry pulse from the counter
//   SEG  out  7  segments {g,f,e,d,c,b,a}, registered
//   DP   out  1  decimal point, registered
//   AN   out  2  one-hot digit enables, AN[0] = ones, AN[1] = tens
//   ERR  out  1  captured value holds a nibble above 9
module seg_scan_8421_2b #(
  parameter int SCAN_DIV       = 1000,
  parameter int STRETCH_LEN    = 50000,
  parameter int BLANK_LZ       = 1,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic       CP,
  input  logic       CR,
  input  logic       EN,
  input  logic       LD,
  input  logic [7:0] D,
  input  logic       TC,
  output logic [6:0] SEG,
  output logic       DP,
  output logic [1:0] AN,
  output logic       ERR
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(STRETCH_LEN + 1);
  localparam logic [PW-1:0] PRESC_LAST   = PW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STRETCH_LOAD = SW'(STRETCH_LEN);

  // Output polarity: XOR with this turns active-high patterns into the
  // level the panel wants. "Off" is therefore simply the polarity itself.
  localparam logic       POL     = (SEG_ACTIVE_LOW != 0);
  localparam logic [6:0] POL7    = {7{POL}};
  localparam logic       BLANK_EN = (BLANK_LZ != 0);

  typedef enum logic {
    ONES = 1'b0,
    TENS = 1'b1
  } digit_t;

  // Active-high {g..a}; anything above 9 shows an "E".
  function automatic logic [6:0] dec7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h79;
    endcase
    return s;
  endfunction

  logic [7:0]    latch_reg;
  digit_t        state_reg, state_next;
  logic [PW-1:0] presc_reg, presc_next;
  logic [SW-1:0] stretch_reg, stretch_next;

  logic [6:0]    seg_reg, seg_next;
  logic          dp_reg, dp_next;
  logic [1:0]    an_reg, an_next;
  logic          err_reg, err_next;

  // Per-nibble decode and range check of the captured value.
  logic [6:0]    nib_seg [2];
  logic [1:0]    nib_bad;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_nib
      assign nib_seg[gi] = dec7(latch_reg[gi*4 +: 4]);
      assign nib_bad[gi] = (latch_reg[gi*4 +: 4] > 4'd9);
    end
  endgenerate

  // Capture register: independent of scan enable.
  always_ff @(posedge CP or negedge CR) begin
    if (!CR) begin
      latch_reg <= 8'h00;
    end else if (LD) begin
      latch_reg <= D;
    end
  end

  // Digit FSM and prescaler state.
  always_ff @(posedge CP or negedge CR) begin
    if (!CR) begin
      state_reg <= ONES;
      presc_reg <= '0;
    end else begin
      state_reg <= state_next;
      presc_reg <= presc_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    presc_next = presc_reg;
    if (EN) begin
      if (presc_reg == PRESC_LAST) begin
        presc_next = '0;
        state_next = (state_reg == ONES) ? TENS : ONES;
      end else begin
        presc_next = presc_reg + PW'(1);
      end
    end
  end

  // Carry stretcher: a new TC always reloads, including on the edge where the
  // count would otherwise have expired.
  always_comb begin
    stretch_next = stretch_reg;
    if (TC) begin
      stretch_next = STRETCH_LOAD;
    end else if (stretch_reg != '0) begin
      stretch_next = stretch_reg - SW'(1);
    end
  end

  always_ff @(posedge CP or negedge CR) begin
    if (!CR) begin
      stretch_reg <= '0;
    end else begin
      stretch_reg <= stretch_next;
    end
  end

  // Output stage, computed from the current (pre-edge) state so every output
  // lags its source by exactly one clock.
  always_comb begin
    seg_next = 7'h00;
    dp_next  = 1'b0;
    an_next  = 2'b00;
    err_next = |nib_bad;
    if (EN) begin
      if (state_reg == ONES) begin
        an_next  = 2'b01;
        seg_next = nib_seg[0];
        dp_next  = (stretch_reg != '0);
      end else begin
        an_next  = 2'b10;
        seg_next = (BLANK_EN && (latch_reg[7:4] == 4'd0)) ? 7'h00 : nib_seg[1];
      end
    end
  end

  always_ff @(posedge CP or negedge CR) begin
    if (!CR) begin
      seg_reg <= POL7;
      dp_reg  <= POL;
      an_reg  <= 2'b00;
      err_reg <= 1'b0;
    end else begin
      seg_reg <= seg_next ^ POL7;
      dp_reg  <= dp_next ^ POL;
      an_reg  <= an_next;
      err_reg <= err_next;
    end
  end

  assign SEG = seg_reg;
  assign DP  = dp_reg;
  assign AN  = an_reg;
  assign ERR = err_reg;

endmodule

// File: tb/tb_seg_scan_8421_2b.sv
// Directed bench for seg_scan_8421_2b. Three instances share the stimulus:
// u_hi (blanking on, active-high), u_nb (blanking off) and u_al (active-low).
module tb_seg_scan_8421_2b;

  logic       CP = 1'b0;
  logic       CR = 1'b1;
  logic       EN = 1'b0;
  logic       LD = 1'b0;
  logic [7:0] D  = 8'h00;
  logic       TC = 1'b0;

  logic [6:0] seg_hi, seg_nb, seg_al;
  logic       dp_hi, dp_nb, dp_al;
  logic [1:0] an_hi, an_nb, an_al;
  logic       err_hi, err_nb, err_al;

  int checks = 0;
  int errors = 0;

  always #5 CP = ~CP;

  seg_scan_8421_2b #(.SCAN_DIV(4), .STRETCH_LEN(3), .BLANK_LZ(1), .SEG_ACTIVE_LOW(0)) u_hi (
    .CP(CP), .CR(CR), .EN(EN), .LD(LD), .D(D), .TC(TC),
    .SEG(seg_hi), .DP(dp_hi), .AN(an_hi), .ERR(err_hi)
  );

  seg_scan_8421_2b #(.SCAN_DIV(4), .STRETCH_LEN(3), .BLANK_LZ(0), .SEG_ACTIVE_LOW(0)) u_nb (
    .CP(CP), .CR(CR), .EN(EN), .LD(LD), .D(D), .TC(TC),
    .SEG(seg_nb), .DP(dp_nb), .AN(an_nb), .ERR(err_nb)
  );

  seg_scan_8421_2b #(.SCAN_DIV(4), .STRETCH_LEN(3), .BLANK_LZ(1), .SEG_ACTIVE_LOW(1)) u_al (
    .CP(CP), .CR(CR), .EN(EN), .LD(LD), .D(D), .TC(TC),
    .SEG(seg_al), .DP(dp_al), .AN(an_al), .ERR(err_al)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  // Clear everything, release CR between edges with all inputs idle.
  task automatic do_reset();
    EN = 1'b0; LD = 1'b0; TC = 1'b0; D = 8'h00;
    CR = 1'b0;
    tick();
    CR = 1'b1;
  endtask

  task automatic test_reset();
    #1 CR = 1'b0;
    #1;
    checks++;
    if (an_hi !== 2'b00) begin errors++; $display("FAIL reset_an: got %b expected 00", an_hi); end
    checks++;
    if (seg_hi !== 7'h00) begin errors++; $display("FAIL reset_seg: got %h expected 00", seg_hi); end
    checks++;
    if (dp_hi !== 1'b0 || err_hi !== 1'b0) begin
      errors++; $display("FAIL reset_dp_err: got dp=%b err=%b expected 0 0", dp_hi, err_hi);
    end
    checks++;
    if (seg_al !== 7'h7F || dp_al !== 1'b1) begin
      errors++; $display("FAIL reset_active_low: got seg=%h dp=%b expected 7f 1", seg_al, dp_al);
    end
    tick();
    CR = 1'b1;
  endtask

  task automatic test_scan();
    logic [1:0] exp_an;
    do_reset();
    EN = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      tick();
      exp_an = ((((n - 1) / 4) % 2) == 0) ? 2'b01 : 2'b10;
      checks++;
      if (an_hi !== exp_an) begin
        errors++; $display("FAIL scan_an edge %0d: got %b expected %b", n, an_hi, exp_an);
      end
    end
  endtask

  task automatic test_blank();
    do_reset();
    LD = 1'b1; D = 8'h05;
    tick();
    LD = 1'b0; EN = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (n == 2) begin
        checks++;
        if (seg_hi !== 7'h6D) begin errors++; $display("FAIL blank_ones: got %h expected 6d", seg_hi); end
        checks++;
        if (seg_al !== 7'h12 || dp_al !== 1'b1) begin
          errors++; $display("FAIL blank_ones_al: got seg=%h dp=%b expected 12 1", seg_al, dp_al);
        end
      end
      if (n == 6) begin
        checks++;
        if (seg_hi !== 7'h00) begin errors++; $display("FAIL blank_tens: got %h expected 00", seg_hi); end
        checks++;
        if (seg_nb !== 7'h3F) begin errors++; $display("FAIL noblank_tens: got %h expected 3f", seg_nb); end
        checks++;
        if (seg_al !== 7'h7F) begin errors++; $display("FAIL blank_tens_al: got %h expected 7f", seg_al); end
      end
    end
  endtask

  task automatic test_decode();
    do_reset();
    LD = 1'b1; D = 8'h39;
    tick();
    LD = 1'b0; EN = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      tick();
      case (n)
        2: begin
          checks++;
          if (seg_hi !== 7'h6F || err_hi !== 1'b0) begin
            errors++; $display("FAIL dec_ones_9: got seg=%h err=%b expected 6f 0", seg_hi, err_hi);
          end
        end
        6: begin
          checks++;
          if (seg_hi !== 7'h4F) begin errors++; $display("FAIL dec_tens_3: got %h expected 4f", seg_hi); end
        end
        8: begin
          LD = 1'b1; D = 8'h3C;
        end
        9: begin
          LD = 1'b0;
          checks++;
          if (seg_hi !== 7'h6F || err_hi !== 1'b0) begin
            errors++; $display("FAIL dec_latency: got seg=%h err=%b expected 6f 0", seg_hi, err_hi);
          end
        end
        10: begin
          checks++;
          if (seg_hi !== 7'h79 || err_hi !== 1'b1) begin
            errors++; $display("FAIL dec_ones_c: got seg=%h err=%b expected 79 1", seg_hi, err_hi);
          end
        end
        13: begin
          checks++;
          if (seg_hi !== 7'h4F || err_hi !== 1'b1) begin
            errors++; $display("FAIL dec_tens_err: got seg=%h err=%b expected 4f 1", seg_hi, err_hi);
          end
          LD = 1'b1; D = 8'h00;
        end
        14: begin
          LD = 1'b0;
          checks++;
          if (err_hi !== 1'b1) begin errors++; $display("FAIL err_hold: got %b expected 1", err_hi); end
        end
        15: begin
          checks++;
          if (err_hi !== 1'b0 || seg_hi !== 7'h00) begin
            errors++; $display("FAIL err_clear: got err=%b seg=%h expected 0 00", err_hi, seg_hi);
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic test_stretch();
    logic exp_dp;
    do_reset();
    EN = 1'b1; TC = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (n == 1 || n == 13 || n == 16) TC = 1'b0;
      if (n == 12 || n == 15) TC = 1'b1;
      if (n <= 4 || n == 9 || n == 14 || n >= 17) begin
        exp_dp = ((n >= 2 && n <= 4) || (n >= 17 && n <= 19));
        checks++;
        if (dp_hi !== exp_dp) begin
          errors++; $display("FAIL stretch_dp edge %0d: got %b expected %b", n, dp_hi, exp_dp);
        end
      end
    end
  endtask

  task automatic test_en_hold();
    logic [1:0] exp_an;
    do_reset();
    EN = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (n == 2) EN = 1'b0;
      if (n == 5) EN = 1'b1;
      exp_an = (n >= 3 && n <= 5) ? 2'b00 : (n == 8) ? 2'b10 : 2'b01;
      checks++;
      if (an_hi !== exp_an) begin
        errors++; $display("FAIL en_hold_an edge %0d: got %b expected %b", n, an_hi, exp_an);
      end
      if (n == 3) begin
        checks++;
        if (seg_al !== 7'h7F || dp_al !== 1'b1 || seg_hi !== 7'h00) begin
          errors++;
          $display("FAIL en_dark: got hi=%h al=%h dp_al=%b expected 00 7f 1", seg_hi, seg_al, dp_al);
        end
      end
    end
  endtask

  task automatic test_async_clear();
    do_reset();
    LD = 1'b1; D = 8'h47;
    tick();
    LD = 1'b0; EN = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      tick();
      if (n == 4) TC = 1'b1;
      if (n == 5) TC = 1'b0;
    end
    checks++;
    if (an_hi !== 2'b10 || seg_hi !== 7'h66) begin
      errors++; $display("FAIL pre_clear: got an=%b seg=%h expected 10 66", an_hi, seg_hi);
    end
    #2 CR = 1'b0;
    #1;
    checks++;
    if (an_hi !== 2'b00 || seg_hi !== 7'h00 || dp_hi !== 1'b0 || err_hi !== 1'b0) begin
      errors++;
      $display("FAIL async_clear: got an=%b seg=%h dp=%b err=%b expected 00 00 0 0",
               an_hi, seg_hi, dp_hi, err_hi);
    end
    checks++;
    if (seg_al !== 7'h7F || dp_al !== 1'b1) begin
      errors++; $display("FAIL async_clear_al: got seg=%h dp=%b expected 7f 1", seg_al, dp_al);
    end
    #1 CR = 1'b1;
    tick();
    checks++;
    if (an_hi !== 2'b01 || seg_hi !== 7'h3F || dp_hi !== 1'b0) begin
      errors++;
      $display("FAIL restart: got an=%b seg=%h dp=%b expected 01 3f 0", an_hi, seg_hi, dp_hi);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blank();
    test_decode();
    test_stretch();
    test_en_hold();
    test_async_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
